// File: rtl/uart_if.sv
// Register-bus and PHY handshake signals of the UART controller.
// The slave modport is the controller side; the master modport is the host/PHY side.
interface uart_if;
  logic       wr_en;
  logic       rd_en;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       irq;

  modport slave (
    input  wr_en, rd_en, addr, wdata, tx_ready, rx_data, rx_ready,
    output rdata, rdata_valid, tx_data, tx_valid, irq
  );

  modport master (
    output wr_en, rd_en, addr, wdata, tx_ready, rx_data, rx_ready,
    input  rdata, rdata_valid, tx_data, tx_valid, irq
  );
endinterface

// File: rtl/uart_ctrl.sv
// UART controller: register front end with TX/RX byte FIFOs, sticky error flags and a
// level interrupt. FIFO_DEPTH must be a power of two, at least 2.
module uart_ctrl #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input logic    clk,
  input logic    rst,
  uart_if.slave  bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  typedef logic [AW:0] ptr_t;
  localparam ptr_t PtrOne = ptr_t'(1);

  logic [7:0] r_tx_mem [FIFO_DEPTH];
  logic [7:0] r_rx_mem [FIFO_DEPTH];
  ptr_t       r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic [1:0] r_ier;
  logic       r_rx_ovr, r_tx_ovf;
  logic [7:0] r_rdata;
  logic       r_rdata_valid;
  logic       r_irq;

  logic       w_tx_empty, w_tx_full, w_rx_empty, w_rx_full, w_tx_idle;
  logic       w_tx_push_req, w_tx_push, w_tx_pop, w_tx_flush, w_tx_ovf_set;
  logic       w_rx_pop_req, w_rx_push, w_rx_pop, w_rx_flush, w_rx_ovr_set;
  logic       w_st_clr;
  logic [7:0] w_status, w_rd_mux;

  // Pointers carry an extra wrap bit: equal index with differing MSB means full.
  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]) && (r_tx_wp[AW] != r_tx_rp[AW]);
  assign w_rx_empty = (r_rx_wp == r_rx_rp);
  assign w_rx_full  = (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]) && (r_rx_wp[AW] != r_rx_rp[AW]);
  assign w_tx_idle  = w_tx_empty && bus.tx_ready;

  assign w_tx_flush    = bus.wr_en && (bus.addr == 2'd3) && bus.wdata[0];
  assign w_rx_flush    = bus.wr_en && (bus.addr == 2'd3) && bus.wdata[1];
  assign w_st_clr      = bus.wr_en && (bus.addr == 2'd2);

  assign w_tx_push_req = bus.wr_en && (bus.addr == 2'd0);
  assign w_tx_pop      = !w_tx_empty && bus.tx_ready;
  assign w_tx_push     = w_tx_push_req && (!w_tx_full || w_tx_pop) && !w_tx_flush;
  assign w_tx_ovf_set  = w_tx_push_req && w_tx_full && !w_tx_pop && !w_tx_flush;

  assign w_rx_pop_req  = bus.rd_en && (bus.addr == 2'd0);
  assign w_rx_pop      = w_rx_pop_req && !w_rx_empty;
  assign w_rx_push     = bus.rx_ready && (!w_rx_full || w_rx_pop) && !w_rx_flush;
  assign w_rx_ovr_set  = bus.rx_ready && w_rx_full && !w_rx_pop && !w_rx_flush;

  assign w_status = {3'b000, r_tx_ovf, r_rx_ovr, w_tx_idle, w_tx_full, !w_rx_empty};

  always_comb begin
    w_rd_mux = 8'h00;
    unique case (bus.addr)
      2'd0:    w_rd_mux = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp[AW-1:0]];
      2'd1:    w_rd_mux = {6'b000000, r_ier};
      2'd2:    w_rd_mux = w_status;
      default: w_rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= bus.wdata;
    if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= bus.rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_wp       <= '0;
      r_tx_rp       <= '0;
      r_rx_wp       <= '0;
      r_rx_rp       <= '0;
      r_ier         <= 2'b00;
      r_rx_ovr      <= 1'b0;
      r_tx_ovf      <= 1'b0;
      r_rdata       <= 8'h00;
      r_rdata_valid <= 1'b0;
      r_irq         <= 1'b0;
    end else begin
      // A flush discards queued bytes; a byte handed to the PHY this cycle is already gone.
      if (w_tx_flush) begin
        r_tx_rp <= r_tx_wp;
      end else begin
        if (w_tx_push) r_tx_wp <= r_tx_wp + PtrOne;
        if (w_tx_pop)  r_tx_rp <= r_tx_rp + PtrOne;
      end
      if (w_rx_flush) begin
        r_rx_rp <= r_rx_wp;
      end else begin
        if (w_rx_push) r_rx_wp <= r_rx_wp + PtrOne;
        if (w_rx_pop)  r_rx_rp <= r_rx_rp + PtrOne;
      end
      if (bus.wr_en && (bus.addr == 2'd1)) r_ier <= bus.wdata[1:0];
      r_rx_ovr <= (r_rx_ovr & ~(w_st_clr & bus.wdata[3])) | w_rx_ovr_set;
      r_tx_ovf <= (r_tx_ovf & ~(w_st_clr & bus.wdata[4])) | w_tx_ovf_set;
      if (bus.rd_en) r_rdata <= w_rd_mux;
      r_rdata_valid <= bus.rd_en;
      r_irq <= (r_ier[0] & !w_rx_empty) | (r_ier[1] & w_tx_idle);
    end
  end

  assign bus.tx_valid    = !w_tx_empty;
  assign bus.tx_data     = r_tx_mem[r_tx_rp[AW-1:0]];
  assign bus.rdata       = r_rdata;
  assign bus.rdata_valid = r_rdata_valid;
  assign bus.irq         = r_irq;
endmodule

// File: tb/tb_uart_ctrl.sv
// Scoreboard bench for uart_ctrl: expected read data and TX bytes are queued at issue time
// and checked by a negedge monitor when the DUT presents them.
module tb_uart_ctrl;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] exp_rd[$];
  logic [7:0] exp_tx[$];

  uart_if bus ();

  uart_ctrl #(.FIFO_DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    cyc();
    bus.wr_en = 1'b0;
  endtask

  task automatic reg_rd(input logic [1:0] a, input logic [7:0] e);
    bus.rd_en = 1'b1;
    bus.addr  = a;
    exp_rd.push_back(e);
    cyc();
    bus.rd_en = 1'b0;
  endtask

  task automatic rx_strobe(input logic [7:0] d);
    bus.rx_ready = 1'b1;
    bus.rx_data  = d;
    cyc();
    bus.rx_ready = 1'b0;
  endtask

  // Monitor: reads and PHY transmit accepts are matched against the queues.
  always @(negedge clk) begin
    if (!rst && bus.rdata_valid) begin
      if (exp_rd.size() == 0) chk("unexpected_read", bus.rdata, 8'hxx);
      else chk("rdata", bus.rdata, exp_rd.pop_front());
    end
    if (!rst && bus.tx_valid && bus.tx_ready) begin
      if (exp_tx.size() == 0) chk("unexpected_tx", bus.tx_data, 8'hxx);
      else chk("tx_data", bus.tx_data, exp_tx.pop_front());
    end
  end

  initial begin
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = 2'd0; bus.wdata = 8'h00;
    bus.tx_ready = 1'b0; bus.rx_data = 8'h00; bus.rx_ready = 1'b0;
    rst = 1'b1;
    cyc(); cyc();
    chk("reset_rdata", bus.rdata, 8'h00);
    chk("reset_rdata_valid", {7'b0, bus.rdata_valid}, 8'h00);
    chk("reset_irq", {7'b0, bus.irq}, 8'h00);
    chk("reset_tx_valid", {7'b0, bus.tx_valid}, 8'h00);
    rst = 1'b0;
    cyc();
    reg_rd(2'd2, 8'h00);
    reg_rd(2'd1, 8'h00);

    // TX drain, one accept pulse per byte
    reg_wr(2'd0, 8'h55); reg_wr(2'd0, 8'hA3); reg_wr(2'd0, 8'h0F);
    exp_tx.push_back(8'h55); exp_tx.push_back(8'hA3); exp_tx.push_back(8'h0F);
    repeat (3) begin
      bus.tx_ready = 1'b1; cyc();
      bus.tx_ready = 1'b0; cyc();
    end
    bus.tx_ready = 1'b1;
    reg_rd(2'd2, 8'h04);
    bus.tx_ready = 1'b0;

    // TX overflow
    for (int i = 0; i <= D; i++) reg_wr(2'd0, 8'(i));
    reg_rd(2'd2, 8'h12);
    reg_wr(2'd2, 8'h10);
    reg_rd(2'd2, 8'h02);
    for (int i = 0; i < D; i++) exp_tx.push_back(8'(i));
    bus.tx_ready = 1'b1;
    repeat (D + 2) cyc();
    bus.tx_ready = 1'b0;
    reg_rd(2'd2, 8'h00);

    // RX overrun and read-when-empty
    for (int i = 0; i <= D; i++) rx_strobe(8'(i));
    reg_rd(2'd2, 8'h09);
    for (int i = 0; i < D; i++) reg_rd(2'd0, 8'(i));
    reg_rd(2'd0, 8'h00);
    reg_wr(2'd2, 8'h08);
    reg_rd(2'd2, 8'h00);

    // Push and pop together on a full RX FIFO
    for (int i = 0; i < D; i++) rx_strobe(8'(8'h20 + i));
    bus.rx_ready = 1'b1; bus.rx_data = 8'h7E;
    reg_rd(2'd0, 8'h20);
    bus.rx_ready = 1'b0;
    reg_rd(2'd2, 8'h01);
    for (int i = 1; i < D; i++) reg_rd(2'd0, 8'(8'h20 + i));
    reg_rd(2'd0, 8'h7E);
    reg_rd(2'd2, 8'h00);

    // RX-data interrupt
    reg_wr(2'd1, 8'h01);
    reg_rd(2'd1, 8'h01);
    rx_strobe(8'h41);
    cyc();
    chk("irq_rise", {7'b0, bus.irq}, 8'h01);
    reg_rd(2'd0, 8'h41);
    chk("irq_hold_pop_cycle", {7'b0, bus.irq}, 8'h01);
    cyc();
    chk("irq_fall", {7'b0, bus.irq}, 8'h00);

    // Simultaneous IER read and write returns the old value; TX-idle interrupt
    bus.wr_en = 1'b1; bus.wdata = 8'h02;
    reg_rd(2'd1, 8'h01);
    bus.wr_en = 1'b0;
    reg_rd(2'd1, 8'h02);
    bus.tx_ready = 1'b1;
    cyc(); cyc();
    chk("irq_tx_idle", {7'b0, bus.irq}, 8'h01);
    bus.tx_ready = 1'b0;
    reg_wr(2'd1, 8'h00);
    cyc();
    chk("irq_disabled", {7'b0, bus.irq}, 8'h00);

    // Flushes
    reg_wr(2'd0, 8'hC1); reg_wr(2'd0, 8'hC2); reg_wr(2'd0, 8'hC3);
    reg_wr(2'd3, 8'h01);
    chk("tx_flush_valid", {7'b0, bus.tx_valid}, 8'h00);
    rx_strobe(8'hD1); rx_strobe(8'hD2);
    reg_wr(2'd3, 8'h02);
    reg_rd(2'd0, 8'h00);
    reg_rd(2'd3, 8'h00);

    // Reset with bytes queued in both directions
    for (int i = 0; i < 5; i++) reg_wr(2'd0, 8'(8'h90 + i));
    for (int i = 0; i < 3; i++) rx_strobe(8'(8'hB0 + i));
    chk("tx_valid_before_reset", {7'b0, bus.tx_valid}, 8'h01);
    #2 rst = 1'b1;
    #1 chk("tx_valid_async_reset", {7'b0, bus.tx_valid}, 8'h00);
    cyc();
    rst = 1'b0;
    bus.tx_ready = 1'b1;
    cyc();
    reg_rd(2'd2, 8'h04);
    reg_rd(2'd0, 8'h00);
    bus.tx_ready = 1'b0;

    for (int i = 0; i < 20; i++) begin
      if (exp_rd.size() == 0 && exp_tx.size() == 0) break;
      cyc();
    end
    chk("pending_reads", 8'(exp_rd.size()), 8'h00);
    chk("pending_tx", 8'(exp_tx.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_ctrl.md
UART_CTRL -- requirements
Module: uart_ctrl

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 16, giving the TX and RX FIFO entry count; it SHALL be a power of two, at least 2.
REQ-002 The block SHALL have port clk, input, width 1: the single clock for all logic.
REQ-003 The block SHALL have port rst, input, width 1: asynchronous, active-high reset.
REQ-004 The block SHALL have port wr_en, input, width 1: register write strobe.
REQ-005 The block SHALL have port rd_en, input, width 1: register read strobe.
REQ-006 The block SHALL have port addr, input, width 2: register select.
REQ-007 The block SHALL have port wdata, input, width 8: write data.
REQ-008 The block SHALL have port rdata, output, width 8: registered read data.
REQ-009 The block SHALL have port rdata_valid, output, width 1: rdata is valid this cycle.
REQ-010 The block SHALL have ports tx_data (output, 8), tx_valid (output, 1) and tx_ready (input, 1): the PHY transmit handshake.
REQ-011 The block SHALL have ports rx_data (input, 8) and rx_ready (input, 1): PHY receive data, where rx_ready is a one-cycle strobe per received byte.
REQ-012 The block SHALL have port irq, output, width 1: registered, level-sensitive interrupt.

Function
REQ-013 Register map:
- addr 0, read: RBR, pops the RX FIFO.
- addr 0, write: THR, pushes the TX FIFO.
- addr 1: IER, read/write bits[1:0]; bit0 = RX-data enable, bit1 = TX-empty enable.
- addr 2, read: STATUS.
- addr 2, write: write-1-to-clear of the sticky bits.
- addr 3, write: CTRL; reads return 0.
REQ-014 STATUS SHALL be:
- bit0 rx_nonempty
- bit1 tx_full
- bit2 tx_idle (TX FIFO empty AND tx_ready=1)
- bit3 rx_overrun (sticky)
- bit4 tx_overflow (sticky)
- bits[7:5] = 0
REQ-015 A read SHALL present rdata with rdata_valid=1 on the cycle after rd_en=1; at all other times rdata_valid SHALL be 0 and rdata SHALL hold its last value.
REQ-016 An RBR read with the RX FIFO non-empty SHALL return the head byte and pop it in the rd_en cycle; with the RX FIFO empty it SHALL return 0x00 and not pop.
REQ-017 A THR write with the TX FIFO not full SHALL push wdata; when full, the byte SHALL be dropped and tx_overflow set.
REQ-018 TX sequencing:
- tx_valid SHALL be combinationally equal to "TX FIFO non-empty".
- tx_data SHALL be the TX FIFO head.
- The head SHALL be popped on every cycle with tx_valid=1 and tx_ready=1.
REQ-019 An rx_ready strobe with the RX FIFO not full SHALL push rx_data; when full, the byte SHALL be dropped and rx_overrun set.
REQ-020 Simultaneous push and pop on the same FIFO SHALL both succeed in one cycle, including when the FIFO is full (no overflow/overrun) or empty (the pop is ignored and returns 0x00, the push lands), with occupancy adjusted accordingly.
REQ-021 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide, wrapping modulo 2*FIFO_DEPTH; full SHALL mean equal index with differing MSB, and empty SHALL mean equal pointers.
REQ-022 CTRL write bit0 (TX flush) and bit1 (RX flush) SHALL empty the respective FIFO in one cycle; the bits SHALL be self-clearing.
REQ-023 A flush SHALL take priority over a same-cycle push or pop on that FIFO.
REQ-024 A byte already accepted by the PHY SHALL be unaffected by a TX flush.
REQ-025 A write-1-to-clear of a sticky bit SHALL lose to a same-cycle setting event, leaving the bit set.
REQ-026 irq SHALL be registered as (IER[0] & rx_nonempty) | (IER[1] & tx_idle), using the values at the clock edge.
REQ-027 rd_en and wr_en asserted together SHALL both take effect; a read of STATUS/IER SHALL return the pre-write value.

Reset
REQ-028 While rst=1, the block SHALL hold both FIFOs empty, IER=0, sticky bits=0, rdata=0x00, rdata_valid=0 and irq=0.
REQ-029 On rst=1, tx_valid SHALL drop to 0 without waiting for a clock edge.
REQ-030 Reset asserted mid-transfer SHALL discard all queued bytes; the block SHALL resume from the empty state on the first edge after rst deasserts.

Verification
REQ-031 The bench SHALL cover TX drain:
- Stimulus: write 0x55, 0xA3, 0x0F to THR with tx_ready=1 pulsed once per byte.
- Response: tx_data presents 0x55, 0xA3, 0x0F in order; tx_idle=1 after the last accept.
REQ-032 The bench SHALL cover TX overflow:
- Stimulus: FIFO_DEPTH+1 THR writes with tx_ready=0.
- Response: tx_full=1; the last byte is dropped; STATUS=0x12; writing 0x10 to addr 2 clears bit4.
REQ-033 The bench SHALL cover RX overrun and read-when-empty:
- Stimulus: FIFO_DEPTH+1 rx_ready strobes of values 0..16, then 17 RBR reads.
- Response: rx_overrun=1; reads return 0..15 in order, then 0x00.
REQ-034 The bench SHALL cover a simultaneous event on a full RX FIFO:
- Stimulus: rx_ready strobe of 0x7E in the same cycle as an RBR read.
- Response: the read returns the old head; 0x7E is stored; rx_overrun stays 0.
REQ-035 The bench SHALL cover irq:
- Stimulus: IER=0x01, then one rx_ready strobe of 0x41.
- Response: irq rises within 2 cycles; the RBR read returns 0x41; irq falls the cycle after the pop.
REQ-036 The bench SHALL cover reset mid-operation:
- Stimulus: assert rst with 5 bytes queued in TX and 3 bytes in RX.
- Response: tx_valid=0 immediately; after release, STATUS=0x04 (tx_ready=1) and RBR reads 0x00.
